// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 raster timing generator. Divides CLK down to a pixel
//            strobe, counts pixels/lines, and emits registered sync, active,
//            coordinates and line/frame end pulses.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int STB_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       pix_stb1,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       active,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       line_end,
    output logic       frame_end
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (STB_DIV > 2) ? $clog2(STB_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STB_DIV - 1);

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] c_H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] c_HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;

    logic w_div_last;
    logic w_h_last;
    logic w_v_last;
    logic w_h_act;
    logic w_v_act;
    logic w_hs_n;
    logic w_vs_n;

    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_h_last   = (r_h_cnt == c_H_LAST);
    assign w_v_last   = (r_v_cnt == c_V_LAST);
    assign w_h_act    = (r_h_cnt < c_H_ACT);
    assign w_v_act    = (r_v_cnt < c_V_ACT);
    assign w_hs_n     = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
    assign w_vs_n     = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));

    // Free-running CLK divider; the strobe is a flop so it is glitch-free.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_div    <= '0;
            pix_stb1 <= 1'b0;
        end else begin
            r_div    <= w_div_last ? '0 : r_div + 1'b1;
            pix_stb1 <= w_div_last;
        end
    end

    // Pixel and line counters, stepped by the registered strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_stb1) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
            end
        end
    end

    // Decode registered one CLK behind the counters; the renderer relies on
    // this fixed lag, so do not fold it into the counter stage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            active    <= 1'b0;
            x         <= '0;
            y         <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            VGA_HS    <= w_hs_n;
            VGA_VS    <= w_vs_n;
            active    <= w_h_act && w_v_act;
            x         <= w_h_act ? r_h_cnt : '0;
            y         <= w_v_act ? r_v_cnt[8:0] : '0;
            line_end  <= pix_stb1 && w_h_last;
            frame_end <= pix_stb1 && (r_h_cnt == c_H_ACT_LAST)
                                  && (r_v_cnt == c_V_ACT_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen. Three instances: default
//            geometry, a shrunken geometry that completes many frames, and
//            STB_DIV=2 with default geometry. Expected outputs come from a
//            closed-form raster model indexed by CLK edges since release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic       stb;
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [8:0] y;
        logic       le;
        logic       fe;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    localparam int c_D   [3] = '{4, 4, 2};
    localparam int c_HA  [3] = '{640, 16, 640};
    localparam int c_HFP [3] = '{16, 2, 16};
    localparam int c_HS  [3] = '{96, 3, 96};
    localparam int c_HBP [3] = '{48, 4, 48};
    localparam int c_VA  [3] = '{480, 10, 480};
    localparam int c_VFP [3] = '{10, 2, 10};
    localparam int c_VS  [3] = '{2, 2, 2};
    localparam int c_VBP [3] = '{33, 3, 33};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] stb, hs, vs, act, le, fe;
    logic [9:0] x [3];
    logic [8:0] y [3];
    exp_t       got [3];

    int    errors = 0;
    int    checks = 0;
    int    n_edges = 0;
    exp3_t sb_q[$];

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .CLK(clk), .RST(rst_n), .pix_stb1(stb[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
        .active(act[0]), .x(x[0]), .y(y[0]), .line_end(le[0]), .frame_end(fe[0])
    );

    vga_timing_gen #(
        .STB_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut_b (
        .CLK(clk), .RST(rst_n), .pix_stb1(stb[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
        .active(act[1]), .x(x[1]), .y(y[1]), .line_end(le[1]), .frame_end(fe[1])
    );

    vga_timing_gen #(.STB_DIV(2)) u_dut_c (
        .CLK(clk), .RST(rst_n), .pix_stb1(stb[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
        .active(act[2]), .x(x[2]), .y(y[2]), .line_end(le[2]), .frame_end(fe[2])
    );

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            got[k] = {stb[k], hs[k], vs[k], act[k], x[k], y[k], le[k], fe[k]};
        end
    end

    // Raster model: n = CLK edges since release (0 = in reset). The strobe
    // follows edge n when n is a multiple of D; the decode after edge n sees
    // the pixel number that was current before that edge.
    function automatic exp_t model(int k, int n);
        exp_t e;
        int   ht, vt, c, h, v;
        bit   stb_prev;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n == 0) return e;
        ht       = c_HA[k] + c_HFP[k] + c_HS[k] + c_HBP[k];
        vt       = c_VA[k] + c_VFP[k] + c_VS[k] + c_VBP[k];
        c        = (n >= 2) ? (n - 2) / c_D[k] : 0;
        stb_prev = (n >= 2) && ((n - 1) % c_D[k] == 0);
        h        = c % ht;
        v        = (c / ht) % vt;
        e.stb    = (n % c_D[k] == 0);
        e.act    = (h < c_HA[k]) && (v < c_VA[k]);
        e.hs     = !((h >= c_HA[k] + c_HFP[k]) && (h < c_HA[k] + c_HFP[k] + c_HS[k]));
        e.vs     = !((v >= c_VA[k] + c_VFP[k]) && (v < c_VA[k] + c_VFP[k] + c_VS[k]));
        e.x      = (h < c_HA[k]) ? 10'(h) : 10'd0;
        e.y      = (v < c_VA[k]) ? 9'(v) : 9'd0;
        e.le     = stb_prev && (h == ht - 1);
        e.fe     = stb_prev && (h == c_HA[k] - 1) && (v == c_VA[k] - 1);
        return e;
    endfunction

    function automatic string fmt(exp_t v);
        return $sformatf("{stb%b hs%b vs%b act%b x%0d y%0d le%b fe%b}",
                         v.stb, v.hs, v.vs, v.act, v.x, v.y, v.le, v.fe);
    endfunction

    // Producer: after every edge push the expected outputs of all instances.
    initial begin
        exp3_t e;
        forever begin
            @(posedge clk);
            if (rst_n) n_edges = n_edges + 1;
            else       n_edges = 0;
            #3;
            for (int k = 0; k < 3; k++) e[k] = model(k, rst_n ? n_edges : 0);
            sb_q.push_back(e);
        end
    end

    // Monitor: pop on the falling edge, compare, and accumulate line/frame
    // aggregates measured purely from the DUT outputs.
    initial begin
        exp3_t e;
        int    l_stb [3], l_hsl [3], l_act [3];
        int    f_cyc [3], f_act [3], f_vsl [3];
        bit    l_seen [3], f_seen [3];
        int    ht, vt;
        for (int k = 0; k < 3; k++) begin
            l_seen[k] = 0; f_seen[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (got[k] !== e[k]) begin
                        errors++;
                        $display("FAIL outputs inst%0d t=%0t got=%s exp=%s",
                                 k, $time, fmt(got[k]), fmt(e[k]));
                    end
                    ht = c_HA[k] + c_HFP[k] + c_HS[k] + c_HBP[k];
                    vt = c_VA[k] + c_VFP[k] + c_VS[k] + c_VBP[k];
                    if (!rst_n) begin
                        l_seen[k] = 0; f_seen[k] = 0;
                        l_stb[k] = 0; l_hsl[k] = 0; l_act[k] = 0;
                        f_cyc[k] = 0; f_act[k] = 0; f_vsl[k] = 0;
                    end else begin
                        l_stb[k] += int'(stb[k]);
                        l_hsl[k] += int'(stb[k] && !hs[k]);
                        l_act[k] += int'(stb[k] && act[k]);
                        f_cyc[k] += 1;
                        f_act[k] += int'(stb[k] && act[k]);
                        f_vsl[k] += int'(stb[k] && !vs[k]);
                        if (le[k]) begin
                            if (l_seen[k]) begin
                                checks++;
                                if (l_stb[k] != ht || l_hsl[k] != c_HS[k] ||
                                    (l_act[k] != 0 && l_act[k] != c_HA[k])) begin
                                    errors++;
                                    $display("FAIL line inst%0d strobes=%0d/%0d hs_low=%0d/%0d act=%0d (need 0 or %0d)",
                                             k, l_stb[k], ht, l_hsl[k], c_HS[k], l_act[k], c_HA[k]);
                                end
                            end
                            l_seen[k] = 1;
                            l_stb[k] = 0; l_hsl[k] = 0; l_act[k] = 0;
                        end
                        if (fe[k]) begin
                            if (f_seen[k]) begin
                                checks++;
                                if (f_cyc[k] != ht * vt * c_D[k] || f_act[k] != c_HA[k] * c_VA[k] ||
                                    f_vsl[k] != c_VS[k] * ht) begin
                                    errors++;
                                    $display("FAIL frame inst%0d period=%0d/%0d act=%0d/%0d vs_low=%0d/%0d",
                                             k, f_cyc[k], ht * vt * c_D[k], f_act[k], c_HA[k] * c_VA[k],
                                             f_vsl[k], c_VS[k] * ht);
                                end
                            end
                            f_seen[k] = 1;
                            f_cyc[k] = 0; f_act[k] = 0; f_vsl[k] = 0;
                        end
                    end
                end
            end
        end
    end

    // Stimulus: reset, free run, async reset inside HS, then random resets.
    initial begin
        int w;
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (14000) @(posedge clk);

        w = 0;
        while (hs[0] !== 1'b0 && w < 4000) begin
            @(posedge clk);
            w++;
        end
        checks++;
        if (w >= 4000) begin
            errors++;
            $display("FAIL hs_wait timeout got=%0d cycles required<4000", w);
        end
        repeat ($urandom_range(0, 60)) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (hs[0] !== 1'b1 || x[0] !== 10'd0 || y[0] !== 9'd0) begin
            errors++;
            $display("FAIL async_rst got hs=%b x=%0d y=%0d required hs=1 x=0 y=0",
                     hs[0], x[0], y[0]);
        end
        repeat ($urandom_range(2, 12)) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8000) @(posedge clk);

        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1000, 4000)) @(posedge clk);
            if ($urandom_range(0, 1) == 1) #1;
            else                           #2;
            rst_n = 1'b0;
            repeat ($urandom_range(1, 10)) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat ($urandom_range(1000, 3000)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
